// File: rtl/aes_pkg.sv
// Shared AES definitions for the MixColumns datapath: state/column types,
// the GF(2^8) reduction constant, xtime/gmul helpers and the FSM state enum.
// Optional feature macro used by the consumers of this package: MIX_COLUMNS_INV_EN.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    // x^8 + x^4 + x^3 + x + 1
    localparam logic [8:0] AES_POLY = 9'h11B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    // Multiply by x in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY[7:0] : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add over the bits of b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column (row 0 in the top byte).
// With MIX_COLUMNS_INV_EN defined an inv_i select chooses InvMixColumns.
module mix_single_column
    import aes_pkg::*;
(
`ifdef MIX_COLUMNS_INV_EN
    input  logic     inv_i,
`endif
    input  aes_col_t col_i,
    output aes_col_t col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] f0, f1, f2, f3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    // Forward matrix rows: 02 03 01 01 rotated right one byte per row
    always_comb begin
        f0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        f1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        f2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        f3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

`ifdef MIX_COLUMNS_INV_EN
    logic [7:0] i0, i1, i2, i3;

    // Inverse matrix rows: 0e 0b 0d 09 rotated right one byte per row
    always_comb begin
        i0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        i1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        i2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        i3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end

    assign col_o = inv_i ? {i0, i1, i2, i3} : {f0, f1, f2, f3};
`else
    assign col_o = {f0, f1, f2, f3};
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock (1, 2 or 4), then holds the result
// until the consumer takes it.
// Optional macro MIX_COLUMNS_INV_EN adds the in_inv port and InvMixColumns.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends on ready, and in_ready is combinational
// (it follows out_ready in DONE so a result can be handed off and a new
// state accepted on the same edge).
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         rst_n,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         in_inv,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    mc_state_e  state_q;
    logic [1:0] cnt_q;
    aes_state_t work_q;
    aes_state_t work_d;
    logic       out_valid_q;
    logic       last_col;

    logic [1:0] col_idx [COLS_PER_CYCLE];
    aes_col_t   col_in  [COLS_PER_CYCLE];
    aes_col_t   col_out [COLS_PER_CYCLE];

`ifdef MIX_COLUMNS_INV_EN
    logic inv_q;
`endif

    // One column transformer per column handled in a cycle
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign col_idx[k] = cnt_q + 2'(k);
        assign col_in[k]  = work_q[127 - 32*int'(col_idx[k]) -: 32];

        mix_single_column u_mix (
`ifdef MIX_COLUMNS_INV_EN
            .inv_i (inv_q),
`endif
            .col_i (col_in[k]),
            .col_o (col_out[k])
        );
    end

    // Merge the freshly transformed columns into the working state
    always_comb begin
        work_d = work_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            work_d[127 - 32*int'(col_idx[k]) -: 32] = col_out[k];
        end
    end

    assign last_col = (cnt_q == CNT_LAST);

    // Ready while idle, or while done if the result leaves this very edge
    assign in_ready = rst_n && ((state_q == ST_IDLE) ||
                                ((state_q == ST_DONE) && out_ready));

    assign out_valid = out_valid_q;
    assign out_state = work_q;

    // Control FSM and working register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_state;
                        cnt_q   <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
                        inv_q   <= in_inv;
`endif
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + CNT_STEP;
                    if (last_col) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            work_q  <= in_state;
                            cnt_q   <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
                            inv_q   <= in_inv;
`endif
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
